ex_mem_pipe_reg: RTL and testbench
==================================

// Module: ex_mem_pipe_reg
// PURPOSE
//  Parametrised EX->MEM pipeline register with a valid/ready handshake, so MEM may stall
//  (multi-cycle data memory) without a global enable. Adds flush (squash), x0 write squash,
//  an optional 2-entry skid buffer that breaks the out_ready->in_ready path, forwarding taps
//  for the hazard unit and a saturating MEM-stall counter. Sits between the ALU stage and data memory.
// PARAMETERS
//  DATA_W     32  width of alu_result, write_data, pc_plus4
//  REG_AW     5   register-file address width
//  SKID       1   1: 2-entry skid buffer (registered in_ready); 0: single entry (comb. in_ready)
//  CNT_W      16  width of stall_cnt
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       synchronous, active-high reset
//  flush          in   1       squash every held entry and the incoming one
//  in_valid       in   1       EX presents an instruction
//  in_ready       out  1       register accepts this cycle (transfer = in_valid & in_ready)
//  in_reg_write / in_mem_to_reg / in_mem_write / in_mem_read  in  1 each  control bits
//  in_alu_result  in   DATA_W  ALU result / memory address
//  in_write_data  in   DATA_W  store data
//  in_write_reg   in   REG_AW  destination register
//  in_pc_plus4    in   DATA_W  PC+4 (link value)
//  out_valid      out  1       head entry valid toward MEM
//  out_ready      in   1       MEM consumes head (transfer = out_valid & out_ready)
//  out_*          out  as in_* head-entry fields (same names, out_ prefix)
//  fwd_valid      out  1       out_valid & out_reg_write & ~out_mem_to_reg
//  fwd_reg        out  REG_AW  = out_write_reg
//  fwd_data       out  DATA_W  = out_alu_result
//  stall_cnt      out  CNT_W   cycles with out_valid & ~out_ready, saturating
// BEHAVIOUR
//  - Reset: out_valid, all out_* control bits, out data fields, stall_cnt = 0; occupancy EMPTY.
//    in_ready = 1 from the first cycle after reset is released; inputs during rst are ignored.
//  - Latency 1: accepted at edge N -> visible on out_* after edge N when empty. Strict FIFO order.
//  - Control bits of an invalid entry are always 0 (out_reg_write=0 whenever out_valid=0).
//  - Capture with in_write_reg==0 forces stored reg_write=0 (x0 never written or forwarded).
//  - SKID=1 occupancy FSM EMPTY/ONE/TWO; in_ready = (state!=TWO), a register output:
//      EMPTY: in xfer -> ONE.   ONE: in&out xfer -> ONE; in only -> TWO; out only -> EMPTY.
//      TWO: out xfer -> ONE (skid entry moves to head); no input accepted.
//  - SKID=0: in_ready = ~out_valid | out_ready (combinational); simultaneous in/out xfer replaces head.
//  - Held head entry is stable (all out_* constant) while out_valid & ~out_ready.
//  - flush (priority below rst): at next edge state -> EMPTY, out_valid=0, control bits 0,
//    incoming entry dropped even if in_valid & in_ready; data fields may hold stale values.
//    stall_cnt unaffected. A flush while MEM stalls discards the stalled entry.
//  - stall_cnt += 1 each cycle out_valid & ~out_ready; holds at 2^CNT_W-1; cleared by rst only.
//  - Reset mid-stall or with TWO entries: all entries lost, outputs as reset values.
// STRUCTURE
//  - Header pipe_defs.vh: ex_mem bundle field widths and bit offsets (CTRL_W=4, bundle width
//    BUNDLE_W = 4 + 3*DATA_W + REG_AW), SKID state encodings.
//  - Sub-module pipe_skid_buf #(W, SKID): generic valid/ready 1- or 2-entry buffer with flush;
//    ex_mem_pipe_reg packs/unpacks the bundle, applies x0 squash, control gating, fwd taps, counter.
// TESTING
//  1 Reset then single xfer: alu_result=0x10, write_reg=5, reg_write=1, out_ready=1 ->
//    out_valid=1 one cycle later with 0x10/5, fwd_valid=1, fwd_reg=5; next cycle out_valid=0.
//  2 Back-to-back stream of 8 instrs, out_ready=1 always -> in_ready stays 1, 8 outputs in order, no gaps.
//  3 SKID=1, out_ready=0 for 4 cycles, in_valid=1 -> 2 accepted, in_ready=0 after 2nd,
//    head stable, stall_cnt=4; release -> both drain in order, in_ready=1 again.
//  4 flush with TWO held and in_valid=1 -> next cycle out_valid=0, out_reg_write=0, in_ready=1,
//    incoming never appears; stall_cnt unchanged.
//  5 Load (mem_to_reg=1, reg_write=1, rd=7) -> fwd_valid=0; write_reg=0 with reg_write=1 -> out_reg_write=0.
//  6 CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt=15 and holds; rst mid-stall -> all outputs 0.

Source files
------------

// File: rtl/ex_mem_pipe_reg_pkg.sv
// Shared definitions for the EX->MEM pipeline register: control-bit layout
// inside the packed bundle and the skid-buffer occupancy encoding.
package ex_mem_pipe_reg_pkg;

  localparam int CTRL_W       = 4;
  localparam int CTRL_RW_BIT  = 3;  // reg_write
  localparam int CTRL_M2R_BIT = 2;  // mem_to_reg
  localparam int CTRL_MW_BIT  = 1;  // mem_write
  localparam int CTRL_MR_BIT  = 0;  // mem_read

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready buffer with flush: a 2-entry skid buffer with a registered
// in_ready (SKID=1), or a single entry with combinational in_ready (SKID=0).
module pipe_skid_buf
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter int W    = 8,
  parameter int SKID = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  generate
    if (SKID != 0) begin : g_skid
      skid_state_e  state_r;
      skid_state_e  state_nxt_s;
      logic [W-1:0] head_r;
      logic [W-1:0] skid_r;
      logic         in_ready_r;
      logic         out_valid_r;
      logic         in_xfer_s;
      logic         out_xfer_s;
      logic         load_head_s;
      logic         load_skid_s;
      logic         move_skid_s;

      assign in_xfer_s  = in_valid & in_ready_r;
      assign out_xfer_s = out_valid_r & out_ready;

      // Occupancy next-state and datapath load selects.
      always_comb begin
        state_nxt_s = state_r;
        load_head_s = 1'b0;
        load_skid_s = 1'b0;
        move_skid_s = 1'b0;
        if (flush) begin
          state_nxt_s = SKID_EMPTY;
        end else begin
          case (state_r)
            SKID_EMPTY: begin
              if (in_xfer_s) begin
                state_nxt_s = SKID_ONE;
                load_head_s = 1'b1;
              end else begin
                state_nxt_s = SKID_EMPTY;
              end
            end
            SKID_ONE: begin
              if (in_xfer_s && out_xfer_s) begin
                state_nxt_s = SKID_ONE;
                load_head_s = 1'b1;
              end else if (in_xfer_s) begin
                state_nxt_s = SKID_TWO;
                load_skid_s = 1'b1;
              end else if (out_xfer_s) begin
                state_nxt_s = SKID_EMPTY;
              end else begin
                state_nxt_s = SKID_ONE;
              end
            end
            SKID_TWO: begin
              if (out_xfer_s) begin
                state_nxt_s = SKID_ONE;
                move_skid_s = 1'b1;
              end else begin
                state_nxt_s = SKID_TWO;
              end
            end
            default: begin
              state_nxt_s = SKID_EMPTY;
            end
          endcase
        end
      end

      // State, handshake flags and entry storage.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_r     <= SKID_EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          head_r      <= {W{1'b0}};
          skid_r      <= {W{1'b0}};
        end else begin
          state_r     <= state_nxt_s;
          in_ready_r  <= (state_nxt_s != SKID_TWO);
          out_valid_r <= (state_nxt_s != SKID_EMPTY);
          if (load_head_s) begin
            head_r <= in_data;
          end else if (move_skid_s) begin
            head_r <= skid_r;
          end
          if (load_skid_s) begin
            skid_r <= in_data;
          end
        end
      end

      assign in_ready  = in_ready_r;
      assign out_valid = out_valid_r;
      assign out_data  = head_r;
    end else begin : g_single
      logic         valid_r;
      logic [W-1:0] head_r;
      logic         in_ready_s;
      logic         in_xfer_s;
      logic         out_xfer_s;

      assign in_ready_s = ~valid_r | out_ready;
      assign in_xfer_s  = in_valid & in_ready_s;
      assign out_xfer_s = valid_r & out_ready;

      // Single head entry; a simultaneous in/out transfer replaces it.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_r <= 1'b0;
          head_r  <= {W{1'b0}};
        end else if (flush) begin
          valid_r <= 1'b0;
        end else if (in_xfer_s) begin
          valid_r <= 1'b1;
          head_r  <= in_data;
        end else if (out_xfer_s) begin
          valid_r <= 1'b0;
        end
      end

      assign in_ready  = in_ready_s;
      assign out_valid = valid_r;
      assign out_data  = head_r;
    end
  endgenerate

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register: packs the instruction bundle into a skid buffer,
// squashes x0 writes, gates control bits by valid, drives forwarding taps and a stall counter.
module ex_mem_pipe_reg
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic              in_mem_write,
  input  logic              in_mem_read,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_write_data,
  input  logic [REG_AW-1:0] in_write_reg,
  input  logic [DATA_W-1:0] in_pc_plus4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_write,
  output logic              out_mem_to_reg,
  output logic              out_mem_write,
  output logic              out_mem_read,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_write_data,
  output logic [REG_AW-1:0] out_write_reg,
  output logic [DATA_W-1:0] out_pc_plus4,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int BUNDLE_W = CTRL_W + 3 * DATA_W + REG_AW;
  localparam int REG_LSB  = 0;
  localparam int PC_LSB   = REG_AW;
  localparam int WD_LSB   = REG_AW + DATA_W;
  localparam int ALU_LSB  = REG_AW + 2 * DATA_W;
  localparam int CTRL_LSB = REG_AW + 3 * DATA_W;

  logic [CTRL_W-1:0]   in_ctrl_s;
  logic [BUNDLE_W-1:0] in_bundle_s;
  logic [BUNDLE_W-1:0] out_bundle_s;
  logic [CTRL_W-1:0]   out_ctrl_s;
  logic                head_valid_s;
  logic [CNT_W-1:0]    stall_cnt_r;

  // x0 is hard-wired zero, so a write to it must never reach the register file or forwarding.
  assign in_ctrl_s = {in_reg_write & (in_write_reg != {REG_AW{1'b0}}),
                      in_mem_to_reg, in_mem_write, in_mem_read};
  assign in_bundle_s = {in_ctrl_s, in_alu_result, in_write_data, in_pc_plus4, in_write_reg};

  pipe_skid_buf #(
    .W    (BUNDLE_W),
    .SKID (SKID)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_bundle_s),
    .out_valid (head_valid_s),
    .out_ready (out_ready),
    .out_data  (out_bundle_s)
  );

  // A flushed entry leaves stale data behind; gating keeps its control bits inert.
  assign out_ctrl_s     = out_bundle_s[CTRL_LSB +: CTRL_W] & {CTRL_W{head_valid_s}};
  assign out_valid      = head_valid_s;
  assign out_reg_write  = out_ctrl_s[CTRL_RW_BIT];
  assign out_mem_to_reg = out_ctrl_s[CTRL_M2R_BIT];
  assign out_mem_write  = out_ctrl_s[CTRL_MW_BIT];
  assign out_mem_read   = out_ctrl_s[CTRL_MR_BIT];
  assign out_alu_result = out_bundle_s[ALU_LSB +: DATA_W];
  assign out_write_data = out_bundle_s[WD_LSB +: DATA_W];
  assign out_pc_plus4   = out_bundle_s[PC_LSB +: DATA_W];
  assign out_write_reg  = out_bundle_s[REG_LSB +: REG_AW];

  assign fwd_valid = head_valid_s & out_reg_write & ~out_mem_to_reg;
  assign fwd_reg   = out_write_reg;
  assign fwd_data  = out_alu_result;

  // Saturating count of MEM back-pressure cycles; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (head_valid_s && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed self-checking bench: DUT a (SKID=1, CNT_W=16) and DUT b (SKID=0, CNT_W=4)
// share all inputs; each test task checks the instance relevant to its scenario.
module tb_ex_mem_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_reg_write, in_mem_to_reg, in_mem_write, in_mem_read;
  logic [31:0] in_alu_result, in_write_data, in_pc_plus4;
  logic [4:0]  in_write_reg;

  logic        in_ready_a, out_valid_a, out_reg_write_a, out_mem_to_reg_a, out_mem_write_a, out_mem_read_a;
  logic [31:0] out_alu_result_a, out_write_data_a, out_pc_plus4_a, fwd_data_a;
  logic [4:0]  out_write_reg_a, fwd_reg_a;
  logic        fwd_valid_a;
  logic [15:0] stall_cnt_a;

  logic        in_ready_b, out_valid_b, out_reg_write_b, out_mem_to_reg_b, out_mem_write_b, out_mem_read_b;
  logic [31:0] out_alu_result_b, out_write_data_b, out_pc_plus4_b, fwd_data_b;
  logic [4:0]  out_write_reg_b, fwd_reg_b;
  logic        fwd_valid_b;
  logic [3:0]  stall_cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_reg #(.DATA_W(32), .REG_AW(5), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_mem_write(in_mem_write),
    .in_mem_read(in_mem_read), .in_alu_result(in_alu_result), .in_write_data(in_write_data),
    .in_write_reg(in_write_reg), .in_pc_plus4(in_pc_plus4), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_reg_write(out_reg_write_a), .out_mem_to_reg(out_mem_to_reg_a),
    .out_mem_write(out_mem_write_a), .out_mem_read(out_mem_read_a),
    .out_alu_result(out_alu_result_a), .out_write_data(out_write_data_a),
    .out_write_reg(out_write_reg_a), .out_pc_plus4(out_pc_plus4_a), .fwd_valid(fwd_valid_a),
    .fwd_reg(fwd_reg_a), .fwd_data(fwd_data_a), .stall_cnt(stall_cnt_a)
  );

  ex_mem_pipe_reg #(.DATA_W(32), .REG_AW(5), .SKID(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_mem_write(in_mem_write),
    .in_mem_read(in_mem_read), .in_alu_result(in_alu_result), .in_write_data(in_write_data),
    .in_write_reg(in_write_reg), .in_pc_plus4(in_pc_plus4), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_reg_write(out_reg_write_b), .out_mem_to_reg(out_mem_to_reg_b),
    .out_mem_write(out_mem_write_b), .out_mem_read(out_mem_read_b),
    .out_alu_result(out_alu_result_b), .out_write_data(out_write_data_b),
    .out_write_reg(out_write_reg_b), .out_pc_plus4(out_pc_plus4_b), .fwd_valid(fwd_valid_b),
    .fwd_reg(fwd_reg_b), .fwd_data(fwd_data_b), .stall_cnt(stall_cnt_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_reg_write = 1'b0; in_mem_to_reg = 1'b0; in_mem_write = 1'b0; in_mem_read = 1'b0;
    in_alu_result = 32'h0; in_write_data = 32'h0; in_write_reg = 5'd0; in_pc_plus4 = 32'h0;
  endtask

  task automatic drive_instr(input logic [31:0] alu, input logic [4:0] rd, input logic rw, input logic m2r);
    in_valid = 1'b1; in_alu_result = alu; in_write_reg = rd; in_reg_write = rw;
    in_mem_to_reg = m2r; in_mem_read = m2r; in_mem_write = 1'b0;
    in_write_data = alu ^ 32'h5555_0000; in_pc_plus4 = alu + 32'd4;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1; out_ready = 1'b0;
    drive_instr(32'hDEAD_BEEF, 5'd9, 1'b1, 1'b0);
    step(); step();
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid_a got=%b exp=0", out_valid_a); end
    checks++; if (out_reg_write_a !== 1'b0) begin errors++; $display("FAIL reset_rw_a got=%b exp=0", out_reg_write_a); end
    checks++; if (out_alu_result_a !== 32'h0) begin errors++; $display("FAIL reset_alu_a got=%h exp=0", out_alu_result_a); end
    checks++; if (stall_cnt_a !== 16'd0) begin errors++; $display("FAIL reset_stall_a got=%0d exp=0", stall_cnt_a); end
    checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b got=%b exp=0", out_valid_b); end
    rst = 1'b0;
    drive_idle();
    step();
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready_a got=%b exp=1", in_ready_a); end
    checks++; if (in_ready_b !== 1'b1) begin errors++; $display("FAIL reset_in_ready_b got=%b exp=1", in_ready_b); end
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_ignored_in got=%b exp=0", out_valid_a); end
  endtask

  task automatic test_single_xfer();
    drive_idle();
    drive_instr(32'h10, 5'd5, 1'b1, 1'b0);
    step();
    checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid_a); end
    checks++; if (out_alu_result_a !== 32'h10) begin errors++; $display("FAIL single_alu got=%h exp=10", out_alu_result_a); end
    checks++; if (out_write_reg_a !== 5'd5) begin errors++; $display("FAIL single_rd got=%0d exp=5", out_write_reg_a); end
    checks++; if (fwd_valid_a !== 1'b1) begin errors++; $display("FAIL single_fwd_valid got=%b exp=1", fwd_valid_a); end
    checks++; if (fwd_reg_a !== 5'd5) begin errors++; $display("FAIL single_fwd_reg got=%0d exp=5", fwd_reg_a); end
    checks++; if (fwd_data_a !== 32'h10) begin errors++; $display("FAIL single_fwd_data got=%h exp=10", fwd_data_a); end
    checks++; if (out_pc_plus4_a !== 32'h14) begin errors++; $display("FAIL single_pc got=%h exp=14", out_pc_plus4_a); end
    checks++; if (out_alu_result_b !== 32'h10) begin errors++; $display("FAIL single_alu_b got=%h exp=10", out_alu_result_b); end
    drive_idle();
    step();
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", out_valid_a); end
    checks++; if (out_reg_write_a !== 1'b0) begin errors++; $display("FAIL single_drain_rw got=%b exp=0", out_reg_write_a); end
  endtask

  task automatic test_back_to_back();
    drive_idle();
    drive_instr(32'h100, 5'd1, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i-1, out_valid_a); end
      checks++; if (out_alu_result_a !== 32'h100 + 32'(4*(i-1))) begin errors++; $display("FAIL b2b_alu[%0d] got=%h exp=%h", i-1, out_alu_result_a, 32'h100 + 32'(4*(i-1))); end
      checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i-1, in_ready_a); end
      checks++; if (out_write_reg_b !== 5'(i)) begin errors++; $display("FAIL b2b_rd_b[%0d] got=%0d exp=%0d", i-1, out_write_reg_b, i); end
      if (i < 8) drive_instr(32'h100 + 32'(4*i), 5'(i+1), 1'b1, 1'b0);
      else drive_idle();
    end
    step();
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", out_valid_a); end
  endtask

  task automatic test_skid_stall();
    drive_idle();
    out_ready = 1'b0;
    drive_instr(32'hA0, 5'd10, 1'b1, 1'b0);
    step();
    checks++; if (out_valid_a !== 1'b1 || out_alu_result_a !== 32'hA0) begin errors++; $display("FAIL stall_first got=%b/%h exp=1/a0", out_valid_a, out_alu_result_a); end
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL stall_ready1 got=%b exp=1", in_ready_a); end
    drive_instr(32'hB0, 5'd11, 1'b1, 1'b0);
    step();
    checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL stall_full got=%b exp=0", in_ready_a); end
    checks++; if (stall_cnt_a !== 16'd1) begin errors++; $display("FAIL stall_cnt1 got=%0d exp=1", stall_cnt_a); end
    drive_instr(32'hC0, 5'd12, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (out_alu_result_a !== 32'hA0 || out_write_reg_a !== 5'd10 || out_pc_plus4_a !== 32'hA4) begin errors++; $display("FAIL stall_head_stable[%0d] got=%h/%0d exp=a0/10", k, out_alu_result_a, out_write_reg_a); end
      checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL stall_hold_ready[%0d] got=%b exp=0", k, in_ready_a); end
    end
    checks++; if (stall_cnt_a !== 16'd4) begin errors++; $display("FAIL stall_cnt4 got=%0d exp=4", stall_cnt_a); end
    drive_idle();
    step();
    checks++; if (out_valid_a !== 1'b1 || out_alu_result_a !== 32'hB0) begin errors++; $display("FAIL stall_drain_b got=%b/%h exp=1/b0", out_valid_a, out_alu_result_a); end
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL stall_ready_again got=%b exp=1", in_ready_a); end
    checks++; if (stall_cnt_a !== 16'd4) begin errors++; $display("FAIL stall_cnt_hold got=%0d exp=4", stall_cnt_a); end
    step();
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL stall_empty got=%b exp=0", out_valid_a); end
  endtask

  task automatic test_flush();
    drive_idle();
    out_ready = 1'b0;
    drive_instr(32'hD0, 5'd13, 1'b1, 1'b0);
    step();
    drive_instr(32'hE0, 5'd14, 1'b1, 1'b0);
    step();
    checks++; if (in_ready_a !== 1'b0 || stall_cnt_a !== 16'd5) begin errors++; $display("FAIL flush_setup got=%b/%0d exp=0/5", in_ready_a, stall_cnt_a); end
    flush = 1'b1; out_ready = 1'b1;
    drive_instr(32'hF0, 5'd3, 1'b1, 1'b0);
    step();
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid_a); end
    checks++; if (out_reg_write_a !== 1'b0) begin errors++; $display("FAIL flush_rw got=%b exp=0", out_reg_write_a); end
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", in_ready_a); end
    checks++; if (stall_cnt_a !== 16'd5) begin errors++; $display("FAIL flush_stall got=%0d exp=5", stall_cnt_a); end
    checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL flush_valid_b got=%b exp=0", out_valid_b); end
    drive_idle();
    step();
    checks++; if (out_valid_a !== 1'b0 || fwd_valid_a !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%b/%b exp=0/0", out_valid_a, fwd_valid_a); end
  endtask

  task automatic test_fwd_x0();
    drive_idle();
    drive_instr(32'h200, 5'd7, 1'b1, 1'b1);
    step();
    checks++; if (out_valid_a !== 1'b1 || out_mem_to_reg_a !== 1'b1 || out_mem_read_a !== 1'b1) begin errors++; $display("FAIL load_ctrl got=%b/%b/%b exp=1/1/1", out_valid_a, out_mem_to_reg_a, out_mem_read_a); end
    checks++; if (out_reg_write_a !== 1'b1) begin errors++; $display("FAIL load_rw got=%b exp=1", out_reg_write_a); end
    checks++; if (fwd_valid_a !== 1'b0) begin errors++; $display("FAIL load_fwd got=%b exp=0", fwd_valid_a); end
    drive_instr(32'h300, 5'd0, 1'b1, 1'b0);
    step();
    checks++; if (out_valid_a !== 1'b1 || out_alu_result_a !== 32'h300) begin errors++; $display("FAIL x0_head got=%b/%h exp=1/300", out_valid_a, out_alu_result_a); end
    checks++; if (out_reg_write_a !== 1'b0) begin errors++; $display("FAIL x0_rw got=%b exp=0", out_reg_write_a); end
    checks++; if (fwd_valid_a !== 1'b0) begin errors++; $display("FAIL x0_fwd got=%b exp=0", fwd_valid_a); end
    checks++; if (out_reg_write_b !== 1'b0) begin errors++; $display("FAIL x0_rw_b got=%b exp=0", out_reg_write_b); end
    drive_idle();
    step();
  endtask

  task automatic test_saturate_reset();
    drive_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    drive_instr(32'h40, 5'd8, 1'b1, 1'b0);
    step();
    checks++; if (in_ready_b !== 1'b0) begin errors++; $display("FAIL sat_comb_ready_b got=%b exp=0", in_ready_b); end
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 15) begin
        checks++; if (stall_cnt_b !== 4'd15) begin errors++; $display("FAIL sat_reach got=%0d exp=15", stall_cnt_b); end
      end
    end
    checks++; if (stall_cnt_b !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt_b); end
    checks++; if (stall_cnt_a !== 16'd20) begin errors++; $display("FAIL sat_wide got=%0d exp=20", stall_cnt_a); end
    checks++; if (out_write_reg_b !== 5'd8 || out_alu_result_b !== 32'h40) begin errors++; $display("FAIL sat_head_b got=%0d/%h exp=8/40", out_write_reg_b, out_alu_result_b); end
    rst = 1'b1;
    step();
    checks++; if (out_valid_a !== 1'b0 || out_reg_write_a !== 1'b0 || out_alu_result_a !== 32'h0 || stall_cnt_a !== 16'd0) begin errors++; $display("FAIL rst_mid_a got=%b/%b/%h/%0d exp=0/0/0/0", out_valid_a, out_reg_write_a, out_alu_result_a, stall_cnt_a); end
    checks++; if (out_valid_b !== 1'b0 || out_write_reg_b !== 5'd0 || stall_cnt_b !== 4'd0) begin errors++; $display("FAIL rst_mid_b got=%b/%0d/%0d exp=0/0/0", out_valid_b, out_write_reg_b, stall_cnt_b); end
    rst = 1'b0;
    drive_idle();
    step();
    checks++; if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b/%b exp=1/1", in_ready_a, in_ready_b); end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_single_xfer();
    test_back_to_back();
    test_skid_stall();
    test_flush();
    test_fwd_x0();
    test_saturate_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
